// File: rtl/bht_ckpt_ctrl_if.sv
// Dcache write-port bundle used by the BHT checkpoint sequencer.
// Master drives the request/payload; slave returns the grant.
interface bht_ckpt_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 56
);
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic [63:0]           wdata;
  logic [7:0]            be;
  logic                  gnt;

  modport master (output req, addr, wdata, be, input gnt);
  modport slave  (input req, addr, wdata, be, output gnt);
endinterface

// File: rtl/bht_ckpt_ctrl.sv
// BHT checkpoint sequencer: freezes the BHT, packs entries into 64-bit words and writes them out.
// Optional macro BHT_CKPT_CHECKSUM_EN appends one XOR-of-all-data-words checksum write.
module bht_ckpt_ctrl #(
  parameter int unsigned NR_ENTRIES       = 1024,
  parameter int unsigned ENTRY_BITS       = 3,
  parameter int unsigned ENTRIES_PER_WORD = 21,
  parameter int unsigned ADDR_WIDTH       = 56
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  output logic                          bht_freeze_o,
  output logic [$clog2(NR_ENTRIES)-1:0] rd_idx_o,
  input  logic [ENTRY_BITS-1:0]         rd_data_i,
  bht_ckpt_ctrl_if.master               dc,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned IDX_W  = $clog2(NR_ENTRIES);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned SLOT_W = $clog2(ENTRIES_PER_WORD);
  localparam int unsigned SH_W   = 7;

  typedef enum logic [1:0] {IDLE, PACK, REQ, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      entry_q, entry_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [63:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  req_q, req_d;
  logic [7:0]            be_q, be_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic [SH_W-1:0]       shamt_c;
`ifdef BHT_CKPT_CHECKSUM_EN
  logic [63:0]           csum_q, csum_d;
  logic                  csum_phase_q, csum_phase_d;
`endif

  assign shamt_c = SH_W'(slot_q) * SH_W'(ENTRY_BITS);

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    slot_d  = slot_q;
    word_d  = word_q;
    addr_d  = addr_q;
    req_d   = req_q;
    be_d    = be_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abort_d = abort_q;
`ifdef BHT_CKPT_CHECKSUM_EN
    csum_d       = csum_q;
    csum_phase_d = csum_phase_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          addr_d  = base_addr_i & ~ADDR_WIDTH'(7);
          entry_d = '0;
          slot_d  = '0;
          word_d  = '0;
          abort_d = 1'b0;
          busy_d  = 1'b1;
          state_d = PACK;
`ifdef BHT_CKPT_CHECKSUM_EN
          csum_d       = '0;
          csum_phase_d = 1'b0;
`endif
        end
      end

      PACK: begin
        if (abort_i) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          word_d  = word_q | (64'(rd_data_i) << shamt_c);
          entry_d = entry_q + CNT_W'(1);
          slot_d  = slot_q + SLOT_W'(1);
          if ((slot_q == SLOT_W'(ENTRIES_PER_WORD - 1)) ||
              (entry_q == CNT_W'(NR_ENTRIES - 1))) begin
            req_d   = 1'b1;
            be_d    = 8'hFF;
            state_d = REQ;
          end
        end
      end

      REQ: begin
        // An abort here is remembered; the open request still has to complete
        if (abort_i) abort_d = 1'b1;
        if (dc.gnt) begin
          req_d  = 1'b0;
          be_d   = 8'h00;
          addr_d = addr_q + ADDR_WIDTH'(8);
          word_d = '0;
          slot_d = '0;
`ifdef BHT_CKPT_CHECKSUM_EN
          if (!csum_phase_q) csum_d = csum_q ^ word_q;
`endif
          if (abort_i || abort_q) begin
            abort_d = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else if (entry_q == CNT_W'(NR_ENTRIES)) begin
`ifdef BHT_CKPT_CHECKSUM_EN
            if (!csum_phase_q) begin
              word_d       = csum_q ^ word_q;
              csum_phase_d = 1'b1;
              req_d        = 1'b1;
              be_d         = 8'hFF;
            end else begin
              done_d  = 1'b1;
              state_d = DONE;
            end
`else
            done_d  = 1'b1;
            state_d = DONE;
`endif
          end else begin
            state_d = PACK;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      entry_q <= '0;
      slot_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      be_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
`ifdef BHT_CKPT_CHECKSUM_EN
      csum_q       <= '0;
      csum_phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      slot_q  <= slot_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      be_q    <= be_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
`ifdef BHT_CKPT_CHECKSUM_EN
      csum_q       <= csum_d;
      csum_phase_q <= csum_phase_d;
`endif
    end
  end

  assign bht_freeze_o = busy_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign rd_idx_o     = entry_q[IDX_W-1:0];
  assign dc.req       = req_q;
  assign dc.addr      = addr_q;
  assign dc.wdata     = word_q;
  assign dc.be        = be_q;

endmodule

// File: tb/tb_bht_ckpt_ctrl.sv
// Directed + randomized bench for bht_ckpt_ctrl with a word-level packing model.
// Honours BHT_CKPT_CHECKSUM_EN for the expected word count and checksum word.
module tb_bht_ckpt_ctrl;
  localparam int unsigned NR  = 1024;
  localparam int unsigned EB  = 3;
  localparam int unsigned EPW = 21;
  localparam int unsigned AW  = 56;
  localparam int unsigned DATA_WORDS = (NR + EPW - 1) / EPW;
`ifdef BHT_CKPT_CHECKSUM_EN
  localparam int unsigned TOTAL_WORDS = DATA_WORDS + 1;
`else
  localparam int unsigned TOTAL_WORDS = DATA_WORDS;
`endif
  localparam int unsigned MIN_LAT = NR + TOTAL_WORDS + 1;

  logic          clk = 1'b0;
  logic          rst_n, start, abort;
  logic [AW-1:0] base;
  logic          freeze, busy, done;
  logic [9:0]    rd_idx;
  logic [2:0]    rd_data;
  logic [2:0]    bht [NR];
  int            gnt_mode;   // 0: always high, 1: always low, 2: random
  logic          rnd_gnt = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [AW-1:0] wr_addr [$];
  logic [63:0]   wr_data [$];
  logic [63:0]   exp_w [TOTAL_WORDS];

  bht_ckpt_ctrl_if #(.ADDR_WIDTH(AW)) dc ();

  bht_ckpt_ctrl #(
    .NR_ENTRIES(NR), .ENTRY_BITS(EB), .ENTRIES_PER_WORD(EPW), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .base_addr_i(base), .bht_freeze_o(freeze), .rd_idx_o(rd_idx),
    .rd_data_i(rd_data), .dc(dc), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  assign rd_data = bht[rd_idx];
  assign dc.gnt  = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'b0 : rnd_gnt;

  always @(negedge clk) rnd_gnt <= ($urandom_range(0, 3) != 0);

  // Transaction monitor: every granted write and every done pulse
  always @(posedge clk) begin
    if (rst_n) begin
      if (dc.req && dc.gnt) begin
        wr_addr.push_back(dc.addr);
        wr_data.push_back(dc.wdata);
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill_bht(input bit constant);
    for (int i = 0; i < NR; i++) bht[i] = constant ? 3'b110 : 3'($urandom);
  endtask

  // Expected memory image: entry e lands in word e/EPW at bit offset EB*(e%EPW)
  task automatic build_model();
    for (int w = 0; w < TOTAL_WORDS; w++) exp_w[w] = '0;
    for (int e = 0; e < NR; e++) exp_w[e / EPW] |= 64'(bht[e]) << (EB * (e % EPW));
`ifdef BHT_CKPT_CHECKSUM_EN
    for (int w = 0; w < DATA_WORDS; w++) exp_w[DATA_WORDS] ^= exp_w[w];
`endif
  endtask

  task automatic check_run(input int first, input logic [AW-1:0] b, input int n);
    logic [AW-1:0] ea;
    chk("wr_count", 64'(wr_addr.size() - first), 64'(n));
    for (int w = 0; w < n; w++) begin
      if (first + w < wr_addr.size()) begin
        ea = (b & ~AW'(7)) + AW'(8 * w);
        chk($sformatf("addr[%0d]", w), 64'(wr_addr[first + w]), 64'(ea));
        chk($sformatf("wdata[%0d]", w), wr_data[first + w], exp_w[w]);
      end
    end
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    start = 1'b1;
    base  = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!dc.req && n < 200) begin tick(); n++; end
    chk("req_rise", 64'(dc.req), 64'(1));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 5000) begin tick(); cyc++; end
    chk("done_seen", 64'(done), 64'(1));
    tick();
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("freeze_fall", 64'(freeze), 64'(0));
    chk("busy_fall", 64'(busy), 64'(0));
  endtask

  initial begin
    int first, dc0, cyc, n;
    logic bad;
    logic [AW-1:0] b;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base = '0; gnt_mode = 0;
    fill_bht(1'b1);
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_freeze", 64'(freeze), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_req", 64'(dc.req), 64'(0));
    chk("rst_addr", 64'(dc.addr), 64'(0));
    chk("rst_wdata", dc.wdata, 64'(0));
    chk("rst_be", 64'(dc.be), 64'(0));
    chk("rst_rd_idx", 64'(rd_idx), 64'(0));
    rst_n = 1'b1;
    tick();

    // Constant-pattern full run, grant always high
    build_model();
    first = wr_addr.size();
    do_start(AW'(64'h8000_0003));
    chk("freeze_busy", 64'(freeze), 64'(1));
    wait_done(cyc);
    chk("latency", 64'(cyc), 64'(MIN_LAT));
    check_run(first, AW'(64'h8000_0000), TOTAL_WORDS);
    if (wr_data.size() >= first + DATA_WORDS) begin
      chk("word0_const", wr_data[first], 64'h6DB6_DB6D_B6DB_6DB6);
      chk("word48_const", wr_data[first + 48], 64'h0000_DB6D_B6DB_6DB6);
      chk("addr48_const", 64'(wr_addr[first + 48]), 64'h8000_0180);
    end

    // start and abort together in IDLE: start ignored
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 64'(busy), 64'(0));
    tick();
    chk("start_abort_idle_req", 64'(dc.req), 64'(0));

    // Grant withheld 5 cycles on word 0, random grants afterwards
    fill_bht(1'b0); build_model();
    first = wr_addr.size();
    b = AW'({$urandom, $urandom}) & ~AW'(7);
    gnt_mode = 1;
    do_start(b);
    wait_req();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("stall_req[%0d]", k), 64'(dc.req), 64'(1));
      chk($sformatf("stall_addr[%0d]", k), 64'(dc.addr), 64'(b));
      chk($sformatf("stall_wdata[%0d]", k), dc.wdata, exp_w[0]);
      chk($sformatf("stall_be[%0d]", k), 64'(dc.be), 64'hFF);
      if (k == 5) gnt_mode = 0;
      tick();
    end
    gnt_mode = 2;
    wait_done(cyc);
    check_run(first, b, TOTAL_WORDS);

    // Abort while packing word 10
    fill_bht(1'b0); build_model();
    first = wr_addr.size(); dc0 = done_cnt;
    b = AW'({$urandom, $urandom});
    gnt_mode = 0;
    do_start(b);
    n = 0;
    while ((wr_addr.size() - first) < 10 && n < 1000) begin tick(); n++; end
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_pack_busy", 64'(busy), 64'(0));
    chk("abort_pack_freeze", 64'(freeze), 64'(0));
    bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (dc.req || done) bad = 1'b1;
    end
    chk("abort_pack_quiet", 64'(bad), 64'(0));
    chk("abort_pack_no_done", 64'(done_cnt - dc0), 64'(0));
    check_run(first, b, 10);

    // Abort in REQ with grant delayed 3 cycles
    fill_bht(1'b0); build_model();
    first = wr_addr.size(); dc0 = done_cnt;
    b = AW'({$urandom, $urandom});
    gnt_mode = 1;
    do_start(b);
    wait_req();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_req_held1", 64'(dc.req), 64'(1));
    tick();
    chk("abort_req_held2", 64'(dc.req), 64'(1));
    gnt_mode = 0;
    tick();
    chk("abort_req_idle_busy", 64'(busy), 64'(0));
    chk("abort_req_idle_req", 64'(dc.req), 64'(0));
    tick(); tick();
    chk("abort_req_no_done", 64'(done_cnt - dc0), 64'(0));
    check_run(first, b, 1);

    // Second start while busy is ignored
    fill_bht(1'b0); build_model();
    first = wr_addr.size();
    b = AW'({$urandom, $urandom});
    gnt_mode = 2;
    do_start(b);
    for (int k = 0; k < 100; k++) tick();
    do_start(AW'(64'h1234_5678));
    wait_done(cyc);
    check_run(first, b, TOTAL_WORDS);

    // Reset during REQ, then a wrapping-address run
    gnt_mode = 1;
    do_start(AW'(64'h4000));
    wait_req();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 64'(dc.req), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_freeze", 64'(freeze), 64'(0));
    chk("rst_mid_addr", 64'(dc.addr), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    fill_bht(1'b0); build_model();
    first = wr_addr.size();
    b = AW'(64'hFF_FFFF_FFFF_FFF5);
    gnt_mode = 0;
    do_start(b);
    wait_done(cyc);
    chk("latency_after_rst", 64'(cyc), 64'(MIN_LAT));
    check_run(first, b, TOTAL_WORDS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
